// File: rtl/acquisition_sequencer.sv
// Periodic SPI acquisition trigger: issues one-cycle spi_start requests every divider+1 cycles.
// Define ACQ_SEQ_OVERRUN_COUNT_EN to add a saturating 16-bit skipped-tick counter port.
module acquisition_sequencer #(
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [31:0]            divider,
    input  logic [COUNT_WIDTH-1:0] num_samples,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   spi_busy,
    output logic                   spi_start,
    output logic                   running,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] sample_count,
    output logic                   overrun
`ifdef ACQ_SEQ_OVERRUN_COUNT_EN
    ,
    output logic [15:0]            overrun_count
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    state_e                 state_q, state_d;
    logic [31:0]            period_q, period_d;
    logic [31:0]            div_q, div_d;
    logic [COUNT_WIDTH-1:0] nsamp_q, nsamp_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   req_q, req_d;
    logic                   done_q, done_d;
    logic                   ovr_q, ovr_d;
`ifdef ACQ_SEQ_OVERRUN_COUNT_EN
    logic [15:0]            ovc_q, ovc_d;
`endif

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        div_d    = div_q;
        nsamp_d  = nsamp_q;
        count_d  = count_q;
        ovr_d    = ovr_q;
        req_d    = 1'b0;
        done_d   = 1'b0;
`ifdef ACQ_SEQ_OVERRUN_COUNT_EN
        ovc_d    = ovc_q;
`endif

        case (state_q)
            StIdle: begin
                if (start && !stop && divider != 32'd0) begin
                    state_d  = StRun;
                    div_d    = divider;
                    nsamp_d  = num_samples;
                    period_d = '0;
                    count_d  = '0;
                    ovr_d    = 1'b0;
`ifdef ACQ_SEQ_OVERRUN_COUNT_EN
                    ovc_d    = '0;
`endif
                end
            end

            StRun: begin
                if (period_q >= div_q) begin
                    period_d = '0;
                    if (!spi_busy) begin
                        req_d   = 1'b1;
                        count_d = count_q + COUNT_WIDTH'(1);
                        if (nsamp_q != '0 && count_d == nsamp_q) begin
                            state_d = StDrain;
                        end
                    end else begin
                        // Engine still busy at the trigger instant: skip, keep the cadence.
                        ovr_d = 1'b1;
`ifdef ACQ_SEQ_OVERRUN_COUNT_EN
                        if (ovc_q != 16'hFFFF) begin
                            ovc_d = ovc_q + 16'd1;
                        end
`endif
                    end
                end else begin
                    period_d = period_q + 32'd1;
                end
                // A coincident tick still issues its request before draining.
                if (stop) begin
                    state_d = StDrain;
                end
            end

            StDrain: begin
                // req_q blocks the cycle where the engine has not yet raised spi_busy.
                if (!req_q && !spi_busy) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            period_q <= '0;
            div_q    <= '0;
            nsamp_q  <= '0;
            count_q  <= '0;
            req_q    <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
`ifdef ACQ_SEQ_OVERRUN_COUNT_EN
            ovc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            div_q    <= div_d;
            nsamp_q  <= nsamp_d;
            count_q  <= count_d;
            req_q    <= req_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
`ifdef ACQ_SEQ_OVERRUN_COUNT_EN
            ovc_q    <= ovc_d;
`endif
        end
    end

    assign spi_start    = req_q;
    assign running      = (state_q != StIdle);
    assign done         = done_q;
    assign sample_count = count_q;
    assign overrun      = ovr_q;
`ifdef ACQ_SEQ_OVERRUN_COUNT_EN
    assign overrun_count = ovc_q;
`endif

endmodule
